// File: rtl/local_net_interface.sv
// Router local-port NI: packetizes core messages into flits; headers/bodies are registered (1 cycle), injection stalls on local_full_i.
// Ejection is registered (1 cycle) with no backpressure; NI_RX_CHECK_EN adds sticky rx protocol-error detection.
module local_net_interface #(
    parameter logic [3:0] ROUTER_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid_i,
    input  logic [3:0]  msg_dest_i,
    input  logic [2:0]  msg_len_i,
    output logic        msg_ready_o,
    input  logic        word_valid_i,
    input  logic [14:0] word_i,
    output logic        word_ready_o,
    input  logic        local_full_i,
    output logic [16:0] flit_o,
    input  logic [16:0] flit_i,
    output logic        rx_valid_o,
    output logic [14:0] rx_word_o,
    output logic [3:0]  rx_src_o,
    output logic        rx_last_o,
    output logic        rx_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  dest_q, dest_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  rem_q, rem_d;
    logic [16:0] flit_q, flit_d;

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        len_d        = len_q;
        rem_d        = rem_q;
        flit_d       = '0;
        msg_ready_o  = 1'b0;
        word_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                msg_ready_o = 1'b1;
                if (msg_valid_i) begin
                    dest_d  = msg_dest_i;
                    len_d   = (msg_len_i == 3'd0) ? 3'd1 : msg_len_i;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (!local_full_i) begin
                    flit_d  = {2'b11, dest_q, ROUTER_ID, len_q, 4'h0};
                    rem_d   = len_q;
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                // An underrun or a full router leaves flit_d at zero: a bubble.
                if (!local_full_i && word_valid_i) begin
                    word_ready_o = 1'b1;
                    flit_d       = {2'b10, word_i};
                    rem_d        = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            flit_q  <= flit_d;
        end
    end

    assign flit_o = flit_q;

    logic [3:0]  src_lat_q, src_lat_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  idx_nxt;
    logic        body_ok;
    logic        rx_valid_q, rx_valid_d;
    logic [14:0] rx_word_q, rx_word_d;
    logic [3:0]  rx_src_q, rx_src_d;
    logic        rx_last_q, rx_last_d;

`ifdef NI_RX_CHECK_EN
    logic open_q, open_d;
    logic err_q, err_d;
    assign body_ok  = open_q;
    assign rx_err_o = err_q;
`else
    assign body_ok  = 1'b1;
    assign rx_err_o = 1'b0;
`endif

    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        src_lat_d  = src_lat_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rx_valid_d = 1'b0;
        rx_word_d  = rx_word_q;
        rx_src_d   = rx_src_q;
        rx_last_d  = 1'b0;
`ifdef NI_RX_CHECK_EN
        open_d     = open_q;
        err_d      = err_q;
`endif
        if (flit_i[16]) begin
            if (flit_i[15]) begin
`ifdef NI_RX_CHECK_EN
                if (open_q) err_d = 1'b1;
                open_d = 1'b1;
`endif
                src_lat_d = flit_i[10:7];
                cnt_d     = flit_i[6:4];
                idx_d     = '0;
            end else if (body_ok) begin
                rx_valid_d = 1'b1;
                rx_word_d  = flit_i[14:0];
                rx_src_d   = src_lat_q;
                rx_last_d  = (idx_nxt == cnt_q);
                idx_d      = idx_nxt;
`ifdef NI_RX_CHECK_EN
                if (idx_nxt == cnt_q) open_d = 1'b0;
            end else begin
                err_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_lat_q  <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_word_q  <= '0;
            rx_src_q   <= '0;
            rx_last_q  <= 1'b0;
`ifdef NI_RX_CHECK_EN
            open_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            src_lat_q  <= src_lat_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rx_valid_q <= rx_valid_d;
            rx_word_q  <= rx_word_d;
            rx_src_q   <= rx_src_d;
            rx_last_q  <= rx_last_d;
`ifdef NI_RX_CHECK_EN
            open_q     <= open_d;
            err_q      <= err_d;
`endif
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_word_o  = rx_word_q;
    assign rx_src_o   = rx_src_q;
    assign rx_last_o  = rx_last_q;

endmodule

// File: tb/tb_local_net_interface.sv
// Bench for local_net_interface: directed injection/ejection sequences, an ejection vector table,
// and randomized traffic checked against packet-level expectations.
module tb_local_net_interface;
    localparam logic [3:0] ID = 4'h6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg_valid_i = 1'b0;
    logic [3:0]  msg_dest_i = '0;
    logic [2:0]  msg_len_i = '0;
    logic        msg_ready_o;
    logic        word_valid_i = 1'b0;
    logic [14:0] word_i = '0;
    logic        word_ready_o;
    logic        local_full_i = 1'b0;
    logic [16:0] flit_o;
    logic [16:0] flit_i = '0;
    logic        rx_valid_o;
    logic [14:0] rx_word_o;
    logic [3:0]  rx_src_o;
    logic        rx_last_o;
    logic        rx_err_o;

    local_net_interface #(.ROUTER_ID(ID)) dut (
        .clk(clk), .rst(rst),
        .msg_valid_i(msg_valid_i), .msg_dest_i(msg_dest_i), .msg_len_i(msg_len_i),
        .msg_ready_o(msg_ready_o),
        .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(word_ready_o),
        .local_full_i(local_full_i), .flit_o(flit_o), .flit_i(flit_i),
        .rx_valid_o(rx_valid_o), .rx_word_o(rx_word_o), .rx_src_o(rx_src_o),
        .rx_last_o(rx_last_o), .rx_err_o(rx_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] fin;
        logic        ev;
        logic [14:0] ew;
        logic [3:0]  es;
        logic        el;
    } rxv_t;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] wq[$];
    bit          wgate = 1'b1;
    bit          accepted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] hdr(input logic [3:0] d, input logic [3:0] s, input logic [2:0] c);
        return {2'b11, d, s, c, 4'h0};
    endfunction

    function automatic logic [16:0] body(input logic [14:0] w);
        return {2'b10, w};
    endfunction

    task automatic drive_words();
        word_valid_i = wgate && (wq.size() > 0);
        word_i       = (wq.size() > 0) ? wq[0] : 15'h0;
    endtask

    // Entered at posedge+1; samples handshakes just before the next edge.
    task automatic tick();
        logic wr, mr, full;
        #3;
        wr   = word_ready_o;
        mr   = msg_ready_o & msg_valid_i;
        full = local_full_i;
        if (wr) chk("word_ready_qualified", {31'h0, word_valid_i & ~local_full_i}, 32'h1);
        @(posedge clk);
        #1;
        if (wr && wq.size() > 0) wq.delete(0);
        accepted = mr;
        if (flit_o[16]) chk("flit_after_full_edge", {31'h0, full}, 32'h0);
        else            chk("flit_idle_zero", {15'h0, flit_o}, 32'h0);
        drive_words();
    endtask

    task automatic step_expect(input string name, input logic [16:0] exp);
        tick();
        chk(name, {15'h0, flit_o}, {15'h0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        msg_valid_i = 1'b0;
        local_full_i = 1'b0;
        flit_i = '0;
        wq.delete();
        wgate = 1'b1;
        drive_words();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] d, input logic [2:0] l);
        msg_valid_i = 1'b1;
        msg_dest_i  = d;
        msg_len_i   = l;
        drive_words();
        tick();
        chk("msg_accept", {31'h0, accepted}, 32'h1);
        msg_valid_i = 1'b0;
        chk("msg_ready_busy", {31'h0, msg_ready_o}, 32'h0);
    endtask

    task automatic apply_rx(input rxv_t v, input string tag);
        flit_i = v.fin;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {31'h0, rx_valid_o}, {31'h0, v.ev});
        if (v.ev) begin
            chk({tag, "_word"}, {17'h0, rx_word_o}, {17'h0, v.ew});
            chk({tag, "_src"}, {28'h0, rx_src_o}, {28'h0, v.es});
            chk({tag, "_last"}, {31'h0, rx_last_o}, {31'h0, v.el});
        end else begin
            chk({tag, "_last_idle"}, {31'h0, rx_last_o}, 32'h0);
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rxv_t        tbl[9];
        logic [16:0] exp[$];
        rxv_t        rq[$];

        // Reset values
        #2;
        chk("rst_flit", {15'h0, flit_o}, 32'h0);
        chk("rst_msg_ready", {31'h0, msg_ready_o}, 32'h1);
        chk("rst_word_ready", {31'h0, word_ready_o}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_valid_o}, 32'h0);
        chk("rst_rx_word", {17'h0, rx_word_o}, 32'h0);
        chk("rst_rx_src", {28'h0, rx_src_o}, 32'h0);
        chk("rst_rx_last", {31'h0, rx_last_o}, 32'h0);
        chk("rst_rx_err", {31'h0, rx_err_o}, 32'h0);
        do_reset();

        // Basic two-body packet on consecutive cycles
        wq = '{15'h1234, 15'h0ABC};
        send_msg(4'h3, 3'd2);
        chk("t1_first_cycle", {15'h0, flit_o}, 32'h0);
        step_expect("t1_hdr", 17'h1_8000 | (17'h3 << 11) | (17'(ID) << 7) | (17'h2 << 4));
        step_expect("t1_b0", 17'h1_1234);
        step_expect("t1_b1", 17'h1_0ABC);
        step_expect("t1_after", 17'h0);
        chk("t1_ready_back", {31'h0, msg_ready_o}, 32'h1);

        // Router full for three edges while the header is pending
        wq = '{15'h7FFF};
        send_msg(4'h9, 3'd1);
        local_full_i = 1'b1;
        step_expect("t2_full0", 17'h0);
        step_expect("t2_full1", 17'h0);
        step_expect("t2_full2", 17'h0);
        local_full_i = 1'b0;
        step_expect("t2_hdr", hdr(4'h9, ID, 3'd1));
        step_expect("t2_b0", 17'h1_7FFF);
        step_expect("t2_after", 17'h0);

        // Core underrun for two cycles mid-body
        wq = '{15'h0111, 15'h0222, 15'h0333};
        send_msg(4'hA, 3'd3);
        step_expect("t3_hdr", hdr(4'hA, ID, 3'd3));
        step_expect("t3_b0", body(15'h0111));
        wgate = 1'b0; drive_words();
        step_expect("t3_bub0", 17'h0);
        step_expect("t3_bub1", 17'h0);
        wgate = 1'b1; drive_words();
        step_expect("t3_b1", body(15'h0222));
        step_expect("t3_b2", body(15'h0333));
        step_expect("t3_after", 17'h0);

        // Length 0 behaves as length 1
        wq = '{15'h0055};
        send_msg(4'h5, 3'd0);
        step_expect("t4_hdr", hdr(4'h5, ID, 3'd1));
        step_expect("t4_b0", body(15'h0055));
        step_expect("t4_after", 17'h0);

        // Reset mid-body drops the packet; next message starts fresh
        wq = '{15'h0A01, 15'h0A02, 15'h0A03, 15'h0A04};
        send_msg(4'h2, 3'd4);
        step_expect("t5_hdr", hdr(4'h2, ID, 3'd4));
        step_expect("t5_b0", body(15'h0A01));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_flit", {15'h0, flit_o}, 32'h0);
        chk("t5_rst_ready", {31'h0, msg_ready_o}, 32'h1);
        wq.delete(); drive_words();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_expect("t5_quiet0", 17'h0);
        step_expect("t5_quiet1", 17'h0);
        wq = '{15'h0042};
        send_msg(4'h1, 3'd1);
        step_expect("t5_new_hdr", hdr(4'h1, ID, 3'd1));
        step_expect("t5_new_b0", body(15'h0042));
        step_expect("t5_new_after", 17'h0);

        // Ejection vector table
        do_reset();
        tbl[0] = '{hdr(4'h0, 4'h5, 3'd3), 1'b0, 15'h0, 4'h0, 1'b0};
        tbl[1] = '{17'h1_0111, 1'b1, 15'h0111, 4'h5, 1'b0};
        tbl[2] = '{17'h0_0000, 1'b0, 15'h0, 4'h0, 1'b0};
        tbl[3] = '{17'h1_0222, 1'b1, 15'h0222, 4'h5, 1'b0};
        tbl[4] = '{17'h0_FFFF, 1'b0, 15'h0, 4'h0, 1'b0};
        tbl[5] = '{17'h1_0333, 1'b1, 15'h0333, 4'h5, 1'b1};
        tbl[6] = '{hdr(4'hC, 4'h9, 3'd1), 1'b0, 15'h0, 4'h0, 1'b0};
        tbl[7] = '{17'h1_7ABC, 1'b1, 15'h7ABC, 4'h9, 1'b1};
        tbl[8] = '{17'h0_0000, 1'b0, 15'h0, 4'h0, 1'b0};
        for (int i = 0; i < 9; i++) apply_rx(tbl[i], "rx_tbl");

`ifdef NI_RX_CHECK_EN
        do_reset();
        apply_rx('{17'h1_0123, 1'b0, 15'h0, 4'h0, 1'b0}, "err_stray");
        chk("err_set", {31'h0, rx_err_o}, 32'h1);
        apply_rx('{hdr(4'h0, 4'h4, 3'd1), 1'b0, 15'h0, 4'h0, 1'b0}, "err_hdr");
        apply_rx('{17'h1_0456, 1'b1, 15'h0456, 4'h4, 1'b1}, "err_good");
        chk("err_sticky", {31'h0, rx_err_o}, 32'h1);
        do_reset();
        chk("err_cleared", {31'h0, rx_err_o}, 32'h0);
        apply_rx('{hdr(4'h0, 4'h3, 3'd2), 1'b0, 15'h0, 4'h0, 1'b0}, "err_h1");
        apply_rx('{17'h1_0001, 1'b1, 15'h0001, 4'h3, 1'b0}, "err_h1b");
        apply_rx('{hdr(4'h0, 4'h7, 3'd1), 1'b0, 15'h0, 4'h0, 1'b0}, "err_h2");
        chk("err_midhdr", {31'h0, rx_err_o}, 32'h1);
        apply_rx('{17'h1_0002, 1'b1, 15'h0002, 4'h7, 1'b1}, "err_restart");
        do_reset();
`else
        apply_rx('{17'h1_0123, 1'b1, 15'h0123, 4'h9, 1'b0}, "stray_body");
        chk("err_tied", {31'h0, rx_err_o}, 32'h0);
        do_reset();
`endif

        // Randomized injection against packet-level expectations
        for (int m = 0; m < 40; m++) begin
            logic [3:0] d;
            logic [2:0] l, eff;
            bit         got;
            int         cyc;
            d   = 4'($urandom_range(0, 15));
            l   = 3'($urandom_range(0, 7));
            eff = (l == 3'd0) ? 3'd1 : l;
            exp.push_back(hdr(d, ID, eff));
            for (int k = 0; k < int'(eff); k++) begin
                logic [14:0] w;
                w = 15'($urandom);
                wq.push_back(w);
                exp.push_back(body(w));
            end
            msg_valid_i = 1'b1;
            msg_dest_i  = d;
            msg_len_i   = l;
            got = 1'b0;
            cyc = 0;
            while (exp.size() > 0 && cyc < 400) begin
                local_full_i = ($urandom_range(0, 3) == 0);
                wgate = ($urandom_range(0, 3) != 0);
                drive_words();
                tick();
                cyc++;
                if (accepted) begin
                    got = 1'b1;
                    msg_valid_i = 1'b0;
                end
                if (flit_o[16]) begin
                    if (exp.size() == 0) chk("rand_extra_flit", {15'h0, flit_o}, 32'h0);
                    else chk("rand_flit", {15'h0, flit_o}, {15'h0, exp.pop_front()});
                end
                if (got && exp.size() > 0) chk("rand_ready_busy", {31'h0, msg_ready_o}, 32'h0);
            end
            chk("rand_timeout", exp.size(), 32'h0);
            exp.delete();
            msg_valid_i = 1'b0;
        end
        local_full_i = 1'b0;
        wgate = 1'b1;

        // Randomized well-formed ejection traffic
        do_reset();
        for (int p = 0; p < 30; p++) begin
            logic [3:0] s;
            logic [2:0] c;
            s = 4'($urandom_range(0, 15));
            c = 3'($urandom_range(1, 7));
            rq.push_back('{hdr(4'($urandom), s, c), 1'b0, 15'h0, 4'h0, 1'b0});
            for (int k = 0; k < int'(c); k++) begin
                logic [14:0] w;
                if ($urandom_range(0, 2) == 0)
                    rq.push_back('{{1'b0, 16'($urandom)}, 1'b0, 15'h0, 4'h0, 1'b0});
                w = 15'($urandom);
                rq.push_back('{body(w), 1'b1, w, s, (k == int'(c) - 1)});
            end
        end
        while (rq.size() > 0) apply_rx(rq.pop_front(), "rx_rand");
        chk("rx_rand_no_err", {31'h0, rx_err_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
